// File: rtl/drive_pkg.sv
// -----------------------------------------------------------------------------
// drive_pkg
// Shared definitions for the assist target-current sequencer and the blocks
// that reuse its incline limiter (e.g. brake regeneration).
//   drive_state_e   : sequencer FSM states
//   TORQUE_MIN_DEF  : default torque dead-band offset
//   CAD_THRESH      : cadence at or below this counts as "not turning"
//   CAD_OFFSET      : offset added to cadence to form the cadence factor
//   INCLINE_OFFSET  : bias added to the saturated incline
//   INCLINE_LIM     : upper bound of the incline factor (9-bit unsigned)
// -----------------------------------------------------------------------------
package drive_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        MUL_S = 3'd2,
        MUL_C = 3'd3,
        MUL_I = 3'd4,
        UPD   = 3'd5
    } drive_state_e;

    localparam logic [11:0] TORQUE_MIN_DEF = 12'h380;
    localparam int          CAD_THRESH     = 1;
    localparam int          CAD_OFFSET     = 32;
    localparam int          INCLINE_OFFSET = 256;
    localparam int          INCLINE_LIM    = 511;

endpackage

// File: rtl/incline_limiter.sv
// -----------------------------------------------------------------------------
// incline_limiter
// Combinational incline conditioning: saturate the signed incline to a signed
// 10-bit range (-512..+511), bias it by +256, then clamp to 0..511.
//   incline     in  INCLINE_W  signed incline reading
//   incline_lim out 9          unsigned incline factor 0..511
// -----------------------------------------------------------------------------
module incline_limiter
    import drive_pkg::*;
#(
    parameter int INCLINE_W = 13
) (
    input  logic signed [INCLINE_W-1:0] incline,
    output logic        [8:0]           incline_lim
);

    // Internal width leaves headroom for the +256 bias on the saturated value.
    localparam int XW = ((INCLINE_W > 10) ? INCLINE_W : 10) + 2;

    localparam logic signed [XW-1:0] SAT_HI = XW'(INCLINE_LIM);
    localparam logic signed [XW-1:0] SAT_LO = -SAT_HI - XW'(1);
    localparam logic signed [XW-1:0] OFS    = XW'(INCLINE_OFFSET);

    logic signed [XW-1:0] inc_x;
    logic signed [XW-1:0] inc_sat;
    logic signed [XW-1:0] inc_ofs;

    always_comb begin
        inc_x = {{(XW-INCLINE_W){incline[INCLINE_W-1]}}, incline};

        if (inc_x > SAT_HI) begin
            inc_sat = SAT_HI;
        end else if (inc_x < SAT_LO) begin
            inc_sat = SAT_LO;
        end else begin
            inc_sat = inc_x;
        end

        inc_ofs = inc_sat + OFS;

        if (inc_ofs < 0) begin
            incline_lim = 9'd0;
        end else if (inc_ofs > SAT_HI) begin
            incline_lim = 9'd511;
        end else begin
            incline_lim = inc_ofs[8:0];
        end
    end

endmodule

// File: rtl/desired_drive_seq.sv
// -----------------------------------------------------------------------------
// desired_drive_seq
// Time-multiplexed target-current calculator. On start it captures the rider
// inputs, then forms (torque-deadband) * scale * cadence_factor * incline_lim
// with one shared multiplier over three cycles, saturates the scaled product
// and (optionally) slew-limits the registered target current.
//
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle request; accepted only in IDLE
//   avg_torque   unsigned pedal torque
//   cadence      cadence count
//   not_pedaling forces target_curr to 0 on update (bypasses slew)
//   incline      signed incline
//   scale        assist level 0..7
//   target_curr  registered target current, holds between updates
//   done         one-cycle pulse when target_curr is updated
//   busy         high from the cycle after an accepted start until done
//   state_dbg    current FSM state (drive_state_e encoding)
//
// Handshake: a start seen while busy=0 is accepted at that clock edge; busy is
// high for the next five cycles; done pulses for one cycle with the new
// target_curr while busy is low again, and a start during that done cycle is
// accepted. Starts while busy are dropped.
// -----------------------------------------------------------------------------
module desired_drive_seq
    import drive_pkg::*;
#(
    parameter int                    TORQUE_W   = 12,
    parameter int                    INCLINE_W  = 13,
    parameter int                    CURR_W     = 12,
    parameter logic [TORQUE_W-1:0]   TORQUE_MIN = TORQUE_W'(TORQUE_MIN_DEF),
    parameter int                    SHIFT      = 15,
    parameter bit                    SLEW_EN    = 1'b1,
    parameter logic [CURR_W-1:0]     SLEW_STEP  = CURR_W'(12'h100)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [TORQUE_W-1:0]         avg_torque,
    input  logic [4:0]                  cadence,
    input  logic                        not_pedaling,
    input  logic signed [INCLINE_W-1:0] incline,
    input  logic [2:0]                  scale,
    output logic [CURR_W-1:0]           target_curr,
    output logic                        done,
    output logic                        busy,
    output logic [2:0]                  state_dbg
);

    localparam int PROD_W = TORQUE_W + 18;
    localparam int HI     = SHIFT + CURR_W;

    // Registered state
    drive_state_e                state_q, state_d;
    logic [TORQUE_W-1:0]         avg_q, avg_d;
    logic [4:0]                  cad_q, cad_d;
    logic                        np_q, np_d;
    logic signed [INCLINE_W-1:0] incl_q, incl_d;
    logic [2:0]                  scale_q, scale_d;
    logic [8:0]                  incl_lim_q, incl_lim_d;
    logic [5:0]                  cad_f_q, cad_f_d;
    logic [PROD_W-1:0]           acc_q, acc_d;
    logic [CURR_W-1:0]           tc_q, tc_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;

    // Combinational helpers
    logic [8:0]          incl_lim_c;
    logic [TORQUE_W-1:0] torque_pos_c;
    logic [5:0]          cad_f_c;
    logic [8:0]          mul_op;
    logic [PROD_W-1:0]   mul_res;
    logic                ovf_c;
    logic [CURR_W-1:0]   new_c;
    logic [CURR_W-1:0]   slew_c;

    incline_limiter #(
        .INCLINE_W (INCLINE_W)
    ) u_incline_limiter (
        .incline     (incl_q),
        .incline_lim (incl_lim_c)
    );

    // Operand preparation from the captured inputs
    always_comb begin
        torque_pos_c = (avg_q > TORQUE_MIN) ? (avg_q - TORQUE_MIN) : '0;
        cad_f_c      = (cad_q > 5'(CAD_THRESH)) ? ({1'b0, cad_q} + 6'(CAD_OFFSET)) : 6'd0;
    end

    // Shared multiplier: the second operand is chosen by the current phase.
    always_comb begin
        case (state_q)
            MUL_S:   mul_op = {6'd0, scale_q};
            MUL_C:   mul_op = {3'd0, cad_f_q};
            MUL_I:   mul_op = incl_lim_q;
            default: mul_op = 9'd0;
        endcase
        mul_res = acc_q * PROD_W'(mul_op);
    end

    // Saturate the scaled product, then compute the slew-limited step.
    always_comb begin
        ovf_c = |acc_q[PROD_W-1:HI];
        new_c = ovf_c ? '1 : acc_q[HI-1:SHIFT];

        if (new_c > tc_q) begin
            slew_c = ((new_c - tc_q) > SLEW_STEP) ? (tc_q + SLEW_STEP) : new_c;
        end else begin
            slew_c = ((tc_q - new_c) > SLEW_STEP) ? (tc_q - SLEW_STEP) : new_c;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        avg_d      = avg_q;
        cad_d      = cad_q;
        np_d       = np_q;
        incl_d     = incl_q;
        scale_d    = scale_q;
        incl_lim_d = incl_lim_q;
        cad_f_d    = cad_f_q;
        acc_d      = acc_q;
        tc_d       = tc_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    avg_d   = avg_torque;
                    cad_d   = cadence;
                    np_d    = not_pedaling;
                    incl_d  = incline;
                    scale_d = scale;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                incl_lim_d = incl_lim_c;
                cad_f_d    = cad_f_c;
                acc_d      = PROD_W'(torque_pos_c);
                state_d    = MUL_S;
            end
            MUL_S: begin
                acc_d   = mul_res;
                state_d = MUL_C;
            end
            MUL_C: begin
                acc_d   = mul_res;
                state_d = MUL_I;
            end
            MUL_I: begin
                acc_d   = mul_res;
                state_d = UPD;
            end
            UPD: begin
                // Safety cut: not pedaling drops the current at once.
                if (np_q) begin
                    tc_d = '0;
                end else if (SLEW_EN) begin
                    tc_d = slew_c;
                end else begin
                    tc_d = new_c;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            avg_q      <= '0;
            cad_q      <= '0;
            np_q       <= 1'b0;
            incl_q     <= '0;
            scale_q    <= '0;
            incl_lim_q <= '0;
            cad_f_q    <= '0;
            acc_q      <= '0;
            tc_q       <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            avg_q      <= avg_d;
            cad_q      <= cad_d;
            np_q       <= np_d;
            incl_q     <= incl_d;
            scale_q    <= scale_d;
            incl_lim_q <= incl_lim_d;
            cad_f_q    <= cad_f_d;
            acc_q      <= acc_d;
            tc_q       <= tc_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign target_curr = tc_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_desired_drive_seq.sv
// -----------------------------------------------------------------------------
// tb_desired_drive_seq
// Two instances share the stimulus: u_dut0 loads directly (SLEW_EN=0) and
// u_dut1 slew-limits (SLEW_EN=1). A reference model computes the expected
// result arithmetically from the captured inputs and releases it five cycles
// after the accepted start; every cycle both instances are compared with it.
// Literal expectations pin the model at the key points.
// -----------------------------------------------------------------------------
module tb_desired_drive_seq;
  import drive_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic               start = 1'b0;
  logic [11:0]        avg_torque = '0;
  logic [4:0]         cadence = '0;
  logic               not_pedaling = 1'b0;
  logic signed [12:0] incline = '0;
  logic [2:0]         scale = '0;

  logic [11:0] tc0, tc1;
  logic        done0, done1, busy0, busy1;
  logic [2:0]  st0, st1;

  desired_drive_seq #(.SLEW_EN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .avg_torque(avg_torque),
    .cadence(cadence), .not_pedaling(not_pedaling), .incline(incline),
    .scale(scale), .target_curr(tc0), .done(done0), .busy(busy0),
    .state_dbg(st0)
  );

  desired_drive_seq #(.SLEW_EN(1'b1), .SLEW_STEP(12'h100)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .avg_torque(avg_torque),
    .cadence(cadence), .not_pedaling(not_pedaling), .incline(incline),
    .scale(scale), .target_curr(tc1), .done(done1), .busy(busy1),
    .state_dbg(st1)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int calc_new(input logic [11:0] t, input logic [4:0] c,
                                  input logic signed [12:0] inc, input logic [2:0] s);
    int inc_i, lim, cf, tp;
    longint p, q;
    inc_i = int'(inc);
    if (inc_i > 511) inc_i = 511;
    if (inc_i < -512) inc_i = -512;
    inc_i = inc_i + 256;
    lim = (inc_i < 0) ? 0 : ((inc_i > 511) ? 511 : inc_i);
    cf = (int'(c) > 1) ? int'(c) + 32 : 0;
    tp = (int'(t) > 'h380) ? int'(t) - 'h380 : 0;
    p = longint'(tp) * longint'(s) * longint'(cf) * longint'(lim);
    q = p >> 15;
    return (q > 4095) ? 4095 : int'(q);
  endfunction

  function automatic int slew_to(input int cur, input int tgt);
    if (tgt > cur + 256) return cur + 256;
    if (tgt < cur - 256) return cur - 256;
    return tgt;
  endfunction

  int   m_cnt = 0;
  int   m_new = 0;
  logic m_np = 1'b0;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_tc0 = 0;
  int   m_tc1 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_tc0  <= 0;
      m_tc1  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt  <= 5;
          m_busy <= 1'b1;
          m_new  <= calc_new(avg_torque, cadence, incline, scale);
          m_np   <= not_pedaling;
        end
      end else if (m_cnt == 1) begin
        m_cnt  <= 0;
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_tc0  <= m_np ? 0 : m_new;
        m_tc1  <= m_np ? 0 : slew_to(m_tc1, m_new);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("done0", 32'(done0), 32'(m_done));
      chk("done1", 32'(done1), 32'(m_done));
      chk("busy0", 32'(busy0), 32'(m_busy));
      chk("busy1", 32'(busy1), 32'(m_busy));
      chk("tc0",   32'(tc0),   32'(m_tc0));
      chk("tc1",   32'(tc1),   32'(m_tc1));
    end
  end

  // ---------------- driver tasks ----------------
  int lat;

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0) begin
        seen = 1'b1;
        lat = i + 1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Pulse start with the given inputs, scramble the inputs while busy (they
  // must have been captured), then wait for done.
  task automatic do_op(input logic [11:0] t, input logic [4:0] c, input logic np,
                       input logic signed [12:0] inc, input logic [2:0] s);
    @(posedge clk); #2;
    avg_torque = t; cadence = c; not_pedaling = np; incline = inc; scale = s;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    avg_torque = ~t; cadence = ~c; not_pedaling = ~np; incline = ~inc; scale = ~s;
    wait_done();
  endtask

  // ---------------- directed sequence ----------------
  logic [11:0] slew_exp [6] = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h500, 12'h5BE};
  int ndone;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tc0", 32'(tc0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_state1", 32'(st1), 32'(IDLE));
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Nominal case; slewed instance ramps by 0x100 per update.
    for (int i = 0; i < 6; i++) begin
      do_op(12'h700, 5'd10, 1'b0, 13'sd0, 3'd5);
      chk("latency", 32'(lat), 32'd6);
      chk("nominal_tc0", 32'(tc0), 32'h5BE);
      chk("slew_tc1", 32'(tc1), 32'(slew_exp[i]));
    end
    do_op(12'h700, 5'd10, 1'b0, 13'sd0, 3'd5);
    chk("slew_hold_tc1", 32'(tc1), 32'h5BE);

    // Not pedaling cuts the slewed output straight to zero.
    do_op(12'h700, 5'd10, 1'b1, 13'sd0, 3'd5);
    chk("np_tc1", 32'(tc1), 32'd0);
    chk("np_tc0", 32'(tc0), 32'd0);

    do_op(12'h700, 5'd10, 1'b0, 13'sd0, 3'd5);
    chk("restart_tc1", 32'(tc1), 32'h100);

    // Overflow saturates.
    do_op(12'hFFF, 5'd31, 1'b0, 13'h0FFF, 3'd7);
    chk("ovf_tc0", 32'(tc0), 32'hFFF);
    chk("ovf_tc1", 32'(tc1), 32'h200);

    // Zero-producing operands, each from a non-zero result.
    do_op(12'h700, 5'd10, 1'b0, -13'sd300, 3'd5);
    chk("incl_neg_tc0", 32'(tc0), 32'd0);
    do_op(12'h700, 5'd10, 1'b0, 13'sd0, 3'd5);
    do_op(12'h700, 5'd1, 1'b0, 13'sd0, 3'd5);
    chk("cad1_tc0", 32'(tc0), 32'd0);
    do_op(12'h700, 5'd10, 1'b0, 13'sd0, 3'd5);
    do_op(12'h300, 5'd10, 1'b0, 13'sd0, 3'd5);
    chk("deadband_tc0", 32'(tc0), 32'd0);
    do_op(12'h700, 5'd10, 1'b0, 13'sd0, 3'd5);

    // Extra starts while busy are dropped: exactly one done.
    @(posedge clk); #2;
    avg_torque = 12'h800; cadence = 5'd20; not_pedaling = 1'b0; incline = 13'sd100; scale = 3'd3;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
    end
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("busy_ignore_ndone", 32'(ndone), 32'd1);
    chk("busy_ignore_tc0", 32'(tc0), 32'(calc_new(12'h800, 5'd20, 13'sd100, 3'd3)));

    // Reset during MUL_C aborts without a done pulse.
    @(posedge clk); #2;
    avg_torque = 12'hA00; cadence = 5'd15; incline = 13'sd50; scale = 3'd6;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_rst_state", 32'(st0), 32'(MUL_C));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy0", 32'(busy0), 32'd0);
    chk("midrst_tc0", 32'(tc0), 32'd0);
    chk("midrst_state0", 32'(st0), 32'(IDLE));
    @(posedge clk); #2;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 || done1) ndone++;
    end
    chk("midrst_ndone", 32'(ndone), 32'd0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
